// File: rtl/pipeline_pkg.sv
// Shared ID-stage definitions: immediate mode tags, opcode constants and the
// generated-immediate record stored in the issue skid buffer.
package pipeline_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    SIGN = 3'd1,
    ZERO = 3'd2,
    LUI  = 3'd3,
    BR   = 3'd4,
    JMP  = 3'd5
  } imm_mode_t;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_mode_t       mode;
    logic            illegal;
  } imm_res_t;

  localparam imm_res_t IMM_RES_RST = '{imm: '0, mode: NONE, illegal: 1'b0};

endpackage

// File: rtl/imm_issue_ctrl_if.sv
// IF/ID -> ID/EX handshake bundle for the immediate issue controller.
interface imm_issue_ctrl_if;
  import pipeline_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [XLEN-1:0]       instr;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       imm;
  imm_mode_t             imm_mode;
  logic                  illegal;

  modport master (
    output in_valid, instr, flush, out_ready,
    input  in_ready, out_valid, imm, imm_mode, illegal
  );

  modport slave (
    input  in_valid, instr, flush, out_ready,
    output in_ready, out_valid, imm, imm_mode, illegal
  );

endinterface

// File: rtl/imm_issue_ctrl_imm_gen.sv
// Combinational opcode classifier and immediate extender.
module imm_gen
  import pipeline_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output imm_res_t        res
);

  logic [5:0]  op;
  logic [15:0] i16;

  assign op  = instr[31:26];
  assign i16 = instr[15:0];

  always_comb begin
    res = IMM_RES_RST;
    case (op)
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW: begin
        res.imm  = {{16{i16[15]}}, i16};
        res.mode = SIGN;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        res.imm  = {16'b0, i16};
        res.mode = ZERO;
      end
      OP_LUI: begin
        res.imm  = {i16, 16'b0};
        res.mode = LUI;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
        res.imm  = {{14{i16[15]}}, i16, 2'b00};
        res.mode = BR;
      end
      OP_J, OP_JAL: begin
        res.imm  = {4'b0, instr[25:0], 2'b00};
        res.mode = JMP;
      end
      OP_RTYPE: ;
      default:  res.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_issue_ctrl.sv
// ID-stage immediate issue controller: classifies at the input and holds the
// generated results in a 2-entry skid buffer feeding the ID/EX boundary.
module imm_issue_ctrl
  import pipeline_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int INSTR_W = 32
) (
  input logic              clk,
  input logic              rst,
  imm_issue_ctrl_if.slave  bus
);

  if (DATA_W != 32 || INSTR_W != 32) begin : g_width_chk
    $error("imm_issue_ctrl: DATA_W and INSTR_W must both be 32");
  end

  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;

  skid_state_t state_q, state_d;
  imm_res_t    head_q, head_d;
  imm_res_t    skid_q, skid_d;
  imm_res_t    gen;
  logic        accept, drain;

  imm_gen u_imm_gen (
    .instr (bus.instr),
    .res   (gen)
  );

  // in_ready comes straight from the state flop, so out_ready never reaches it
  assign bus.in_ready  = (state_q != TWO);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.imm       = head_q.imm;
  assign bus.imm_mode  = head_q.mode;
  assign bus.illegal   = head_q.illegal;

  assign accept = bus.in_valid  & bus.in_ready;
  assign drain  = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            head_d  = gen;
          end
        end
        ONE: begin
          if (accept && drain) begin
            head_d = gen;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = gen;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            state_d = ONE;
            head_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= IMM_RES_RST;
      skid_q  <= IMM_RES_RST;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_imm_issue_ctrl.sv
// Directed bench for imm_issue_ctrl: immediate forms, stall, flush and reset.
module tb_imm_issue_ctrl;
  import pipeline_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  imm_issue_ctrl_if bus ();

  imm_issue_ctrl #(.DATA_W(32), .INSTR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [15:0] i);
    return {op, 5'd3, 5'd4, i};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] imm, input imm_mode_t mode,
                         input logic ill);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".imm"},   bus.imm, imm);
    chk({tag, ".mode"},  32'(bus.imm_mode), 32'(mode));
    chk({tag, ".ill"},   32'(bus.illegal), 32'(ill));
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".imm"},   bus.imm, 32'd0);
    chk({tag, ".mode"},  32'(bus.imm_mode), 32'(NONE));
    chk({tag, ".ill"},   32'(bus.illegal), 32'd0);
    chk({tag, ".rdy"},   32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_rst("reset");

    // streaming with out_ready high: one result per cycle
    bus.in_valid = 1'b1;
    bus.instr = mk(OP_ADDI, 16'hFFFC);       step(); chk_out("addi_neg", 32'hFFFFFFFC, SIGN, 1'b0);
    bus.instr = mk(OP_ADDI, 16'h7FFF);       step(); chk_out("addi_pos", 32'h00007FFF, SIGN, 1'b0);
    bus.instr = mk(OP_ORI,  16'h8000);       step(); chk_out("ori",      32'h00008000, ZERO, 1'b0);
    bus.instr = mk(OP_LUI,  16'h1234);       step(); chk_out("lui",      32'h12340000, LUI,  1'b0);
    bus.instr = mk(OP_BEQ,  16'hFFFF);       step(); chk_out("beq",      32'hFFFFFFFC, BR,   1'b0);
    bus.instr = {OP_J, 26'h0000010};         step(); chk_out("j",        32'h00000040, JMP,  1'b0);
    bus.instr = mk(6'h3F,   16'h1234);       step(); chk_out("bad_op",   32'h00000000, NONE, 1'b1);
    bus.instr = mk(OP_RTYPE, 16'h1234);      step(); chk_out("rtype",    32'h00000000, NONE, 1'b0);
    bus.instr = mk(OP_SW,   16'h8001);       step(); chk_out("sw",       32'hFFFF8001, SIGN, 1'b0);
    bus.instr = {OP_JAL, 26'h3FFFFFF};       step(); chk_out("jal_max",  32'h0FFFFFFC, JMP,  1'b0);
    bus.in_valid = 1'b0;
    step();
    chk("drain_empty", 32'(bus.out_valid), 32'd0);

    // backpressure: A, B fill the buffer, C waits at the input
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr = mk(OP_ADDI, 16'h000A); step(); chk_out("bp_A", 32'h0000000A, SIGN, 1'b0);
    chk("bp_rdy1", 32'(bus.in_ready), 32'd1);
    bus.instr = mk(OP_ANDI, 16'h00BB); step(); chk_out("bp_A_hold", 32'h0000000A, SIGN, 1'b0);
    chk("bp_rdy_full", 32'(bus.in_ready), 32'd0);
    bus.instr = mk(OP_LUI,  16'h00CC); step(); chk_out("bp_A_stall", 32'h0000000A, SIGN, 1'b0);
    chk("bp_rdy_full2", 32'(bus.in_ready), 32'd0);
    step();                                   chk_out("bp_A_stall2", 32'h0000000A, SIGN, 1'b0);
    bus.out_ready = 1'b1;
    step(); chk_out("bp_B", 32'h000000BB, ZERO, 1'b0);
    chk("bp_rdy_free", 32'(bus.in_ready), 32'd1);
    step(); chk_out("bp_C", 32'h00CC0000, LUI, 1'b0);
    bus.in_valid = 1'b0;
    step(); chk("bp_done", 32'(bus.out_valid), 32'd0);

    // flush with two held entries and a third presented
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr = mk(OP_ADDI, 16'h0011); step();
    bus.instr = mk(OP_ADDI, 16'h0022); step();
    chk("fl_full", 32'(bus.in_ready), 32'd0);
    bus.instr = mk(OP_ADDI, 16'h0033);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_rdy",   32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b1;
    step(); chk("fl_gone1", 32'(bus.out_valid), 32'd0);
    step(); chk("fl_gone2", 32'(bus.out_valid), 32'd0);

    // reset with two held entries, then back-to-back traffic
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr = mk(OP_ORI, 16'h0101); step();
    bus.instr = mk(OP_ORI, 16'h0202); step();
    chk("rs_full", 32'(bus.in_ready), 32'd0);
    bus.instr = mk(OP_ORI, 16'h0303);
    bus.flush = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.flush = 1'b0;
    chk_rst("mid_reset");
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      bus.instr = mk(OP_ADDIU, 16'(k * 16'h0111));
      step();
      chk_out("b2b", 32'(k * 32'h0111), SIGN, 1'b0);
      chk("b2b_rdy", 32'(bus.in_ready), 32'd1);
    end
    bus.in_valid = 1'b0;
    step(); chk("b2b_done", 32'(bus.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
